// File: rtl/mux_scan_n.sv
// mux_scan_n: registered N-channel multiplexer with manual select and auto-scan.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (priority over hold and mode)
//   in_bus     CHANNELS*WIDTH packed channel data, channel k at [k*WIDTH +: WIDTH]
//   sel        manual channel select (SELW bits)
//   mode       0 = manual select, 1 = auto-scan
//   hold       1 freezes every register (scan_wrap forced low)
//   out        registered selected data
//   out_ch     index of the channel currently on out
//   out_valid  out holds data from a legal channel
//   scan_wrap  one-cycle pulse on the scan advance from CHANNELS-1 back to 0
module mux_scan_n #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 3,
  localparam int SELW     = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out,
  output logic [SELW-1:0]           out_ch,
  output logic                      out_valid,
  output logic                      scan_wrap
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [WIDTH-1:0] out_q, out_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             scan_wrap_q, scan_wrap_d;
  logic [SELW-1:0]  cur_ch_q, cur_ch_d;
  logic [DW-1:0]    dwell_q, dwell_d;

  logic [WIDTH-1:0] sel_data, cur_data;
  logic             sel_legal;

  // Decode by comparison rather than a computed part-select, so an
  // out-of-range sel (non power-of-2 CHANNELS) simply matches nothing.
  always_comb begin
    sel_data  = '0;
    sel_legal = 1'b0;
    cur_data  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SELW'(k)) begin
        sel_data  = in_bus[k*WIDTH +: WIDTH];
        sel_legal = 1'b1;
      end
      if (cur_ch_q == SELW'(k)) cur_data = in_bus[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    scan_wrap_d = 1'b0;
    cur_ch_d    = cur_ch_q;
    dwell_d     = dwell_q;
    if (hold) begin
      // everything frozen; only the wrap pulse is dropped
    end else if (!mode) begin
      out_d       = sel_legal ? sel_data : '0;
      out_ch_d    = sel;
      out_valid_d = sel_legal;
      // Clearing scan state here makes a later switch to scan start at channel 0.
      cur_ch_d    = '0;
      dwell_d     = '0;
    end else begin
      out_d       = cur_data;
      out_ch_d    = cur_ch_q;
      out_valid_d = 1'b1;
      if (dwell_q == DW'(DWELL - 1)) begin
        dwell_d = '0;
        if (cur_ch_q == SELW'(CHANNELS - 1)) begin
          cur_ch_d    = '0;
          scan_wrap_d = 1'b1;
        end else begin
          cur_ch_d = cur_ch_q + SELW'(1);
        end
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      scan_wrap_q <= 1'b0;
      cur_ch_q    <= '0;
      dwell_q     <= '0;
    end else begin
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      scan_wrap_q <= scan_wrap_d;
      cur_ch_q    <= cur_ch_d;
      dwell_q     <= dwell_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n: a 4-channel and a 3-channel instance.
// Each step drives inputs and queues the outputs expected after the next edge;
// a monitor pops one entry per edge and compares.
module tb_mux_scan_n;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [31:0] in4 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
  logic [1:0]  sel4 = '0;
  logic        rst4 = 1'b1, mode4 = 1'b0, hold4 = 1'b0;
  logic [7:0]  out4;
  logic [1:0]  ch4;
  logic        v4, w4;

  // 3-channel instance
  logic [23:0] in3 = {8'hC3, 8'hB2, 8'hA1};
  logic [1:0]  sel3 = '0;
  logic        rst3 = 1'b1, mode3 = 1'b0, hold3 = 1'b0;
  logic [7:0]  out3;
  logic [1:0]  ch3;
  logic        v3, w3;

  mux_scan_n #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) dut4 (
    .clk(clk), .rst(rst4), .in_bus(in4), .sel(sel4), .mode(mode4), .hold(hold4),
    .out(out4), .out_ch(ch4), .out_valid(v4), .scan_wrap(w4));

  mux_scan_n #(.WIDTH(8), .CHANNELS(3), .DWELL(3)) dut3 (
    .clk(clk), .rst(rst3), .in_bus(in3), .sel(sel3), .mode(mode3), .hold(hold3),
    .out(out3), .out_ch(ch3), .out_valid(v3), .scan_wrap(w3));

  typedef struct {
    int         tag;
    logic [7:0] o;
    logic [1:0] ch;
    logic       v;
    logic       w;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;

  task automatic cmp(input string nm, input exp_t e, input logic [7:0] o,
                     input logic [1:0] ch, input logic v, input logic w);
    checks++;
    if (o !== e.o || ch !== e.ch || v !== e.v || w !== e.w) begin
      failures++;
      $display("FAIL %s step%0d got out=%h ch=%0d valid=%b wrap=%b want out=%h ch=%0d valid=%b wrap=%b",
               nm, e.tag, o, ch, v, w, e.o, e.ch, e.v, e.w);
    end
  endtask

  // monitor: outputs are stable 1 time unit after the edge
  always @(posedge clk) begin
    #1;
    if (q4.size() > 0) cmp("dut4", q4.pop_front(), out4, ch4, v4, w4);
    if (q3.size() > 0) cmp("dut3", q3.pop_front(), out3, ch3, v3, w3);
  end

  // which: 0 = 4-channel instance, 1 = 3-channel instance
  task automatic step(input bit which, input bit r, input bit m, input bit h,
                      input logic [1:0] s, input logic [7:0] eo,
                      input logic [1:0] ech, input bit ev, input bit ew);
    exp_t e;
    e.tag = step_no; e.o = eo; e.ch = ech; e.v = ev; e.w = ew;
    step_no++;
    if (which == 1'b0) begin
      rst4 = r; mode4 = m; hold4 = h; sel4 = s; q4.push_back(e);
    end else begin
      rst3 = r; mode3 = m; hold3 = h; sel3 = s; q3.push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    // ---- reset, then manual sweep sel 0..3
    step(0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    step(0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'hA1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 8'hB2, 1, 1, 0);
    step(0, 0, 0, 0, 2, 8'hC3, 2, 1, 0);
    step(0, 0, 0, 0, 3, 8'hD4, 3, 1, 0);

    // ---- 14 scan cycles after reset; sel held at 2 to show it is ignored
    step(0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    step(0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 1, 0, 2, 8'hA1, 0, 1, 0);
    step(0, 0, 1, 0, 2, 8'hA1, 0, 1, 0);
    step(0, 0, 1, 0, 2, 8'hA1, 0, 1, 0);
    step(0, 0, 1, 0, 2, 8'hB2, 1, 1, 0);
    step(0, 0, 1, 0, 2, 8'hB2, 1, 1, 0);
    step(0, 0, 1, 0, 2, 8'hB2, 1, 1, 0);
    step(0, 0, 1, 0, 2, 8'hC3, 2, 1, 0);
    step(0, 0, 1, 0, 2, 8'hC3, 2, 1, 0);
    step(0, 0, 1, 0, 2, 8'hC3, 2, 1, 0);
    step(0, 0, 1, 0, 2, 8'hD4, 3, 1, 0);
    step(0, 0, 1, 0, 2, 8'hD4, 3, 1, 0);
    step(0, 0, 1, 0, 2, 8'hD4, 3, 1, 1); // advance 3 -> 0 on this edge
    step(0, 0, 1, 0, 2, 8'hA1, 0, 1, 0);
    step(0, 0, 1, 0, 2, 8'hA1, 0, 1, 0);

    // ---- hold for 4 cycles during the 2nd B2 cycle
    step(0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    step(0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 1, 0, 0, 8'hA1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 8'hA1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 8'hA1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 8'hB2, 1, 1, 0);
    step(0, 0, 1, 0, 0, 8'hB2, 1, 1, 0);
    step(0, 0, 1, 1, 0, 8'hB2, 1, 1, 0);
    step(0, 0, 1, 1, 3, 8'hB2, 1, 1, 0);
    step(0, 0, 0, 1, 3, 8'hB2, 1, 1, 0); // mode ignored under hold
    step(0, 0, 1, 1, 0, 8'hB2, 1, 1, 0);
    step(0, 0, 1, 0, 0, 8'hB2, 1, 1, 0); // exactly one more B2
    step(0, 0, 1, 0, 0, 8'hC3, 2, 1, 0);
    step(0, 0, 1, 0, 0, 8'hC3, 2, 1, 0);

    // ---- rst during 2nd C3 cycle, with hold also high (rst wins)
    step(0, 1, 1, 1, 0, 8'h00, 0, 0, 0);
    step(0, 0, 1, 0, 0, 8'hA1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 8'hA1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 8'hA1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 8'hB2, 1, 1, 0);
    step(0, 0, 1, 0, 0, 8'hB2, 1, 1, 0);
    step(0, 0, 1, 0, 0, 8'hB2, 1, 1, 0);
    step(0, 0, 1, 0, 0, 8'hC3, 2, 1, 0);

    // ---- mode 1 -> 0 -> 1 mid-dwell on channel 2
    step(0, 0, 0, 0, 1, 8'hB2, 1, 1, 0);
    step(0, 0, 1, 0, 1, 8'hA1, 0, 1, 0);
    in4[7:0] = 8'h5A;                    // mid-dwell data change shows next edge
    step(0, 0, 1, 0, 1, 8'h5A, 0, 1, 0);
    in4[7:0] = 8'hA1;
    step(0, 0, 1, 0, 1, 8'hA1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 8'hB2, 1, 1, 0);

    // ---- 3-channel instance: illegal sel, then legal, then a full scan wrap
    step(1, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    step(1, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    step(1, 0, 0, 0, 3, 8'h00, 3, 0, 0);
    step(1, 0, 0, 0, 2, 8'hC3, 2, 1, 0);
    step(1, 0, 0, 1, 3, 8'hC3, 2, 1, 0); // hold keeps legal data
    step(1, 0, 1, 0, 3, 8'hA1, 0, 1, 0);
    step(1, 0, 1, 0, 3, 8'hA1, 0, 1, 0);
    step(1, 0, 1, 0, 3, 8'hA1, 0, 1, 0);
    step(1, 0, 1, 0, 3, 8'hB2, 1, 1, 0);
    step(1, 0, 1, 0, 3, 8'hB2, 1, 1, 0);
    step(1, 0, 1, 0, 3, 8'hB2, 1, 1, 0);
    step(1, 0, 1, 0, 3, 8'hC3, 2, 1, 0);
    step(1, 0, 1, 0, 3, 8'hC3, 2, 1, 0);
    step(1, 0, 1, 0, 3, 8'hC3, 2, 1, 1); // advance 2 -> 0
    step(1, 0, 1, 0, 3, 8'hA1, 0, 1, 0);

    @(posedge clk);
    #2;
    checks++;
    if (q4.size() != 0 || q3.size() != 0) begin
      failures++;
      $display("FAIL drain got q4=%0d q3=%0d pending want 0", q4.size(), q3.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
